// File: rtl/branch_target_if.sv
// Request/result channel between decode, the branch target unit and fetch redirect.
// The channel also carries flush and the two performance counters.
interface branch_target_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_kind;
  logic [2:0]       in_funct3;
  logic [XLEN-1:0]  in_pc;
  logic [XLEN-1:0]  in_rs1;
  logic [XLEN-1:0]  in_rs2;
  logic [XLEN-1:0]  in_imm;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic             out_taken;
  logic [XLEN-1:0]  out_target;
  logic [XLEN-1:0]  out_link;
  logic [XLEN-1:0]  out_pc;
  logic             out_misalign;
  logic             out_illegal;
  logic [CNT_W-1:0] cnt_resolved;
  logic [CNT_W-1:0] cnt_taken;

  modport master (
    output in_valid, in_kind, in_funct3, in_pc, in_rs1, in_rs2, in_imm, flush, out_ready,
    input  in_ready, out_valid, out_taken, out_target, out_link, out_pc,
           out_misalign, out_illegal, cnt_resolved, cnt_taken
  );

  modport slave (
    input  in_valid, in_kind, in_funct3, in_pc, in_rs1, in_rs2, in_imm, flush, out_ready,
    output in_ready, out_valid, out_taken, out_target, out_link, out_pc,
           out_misalign, out_illegal, cnt_resolved, cnt_taken
  );
endinterface

// File: rtl/branch_target_unit.sv
// RV32I control-transfer resolver: target, link, taken and fault flags in one registered
// stage behind a one-entry valid/ready buffer, plus saturating resolved/taken counters.
module branch_target_unit #(
  parameter int XLEN   = 32,
  parameter int IALIGN = 32,
  parameter int CNT_W  = 32
) (
  input  logic           clk,
  input  logic           rst,
  branch_target_if.slave bus
);
  localparam logic [1:0]      K_NONE   = 2'b00;
  localparam logic [1:0]      K_JAL    = 2'b01;
  localparam logic [1:0]      K_JALR   = 2'b10;
  localparam logic [1:0]      K_BR     = 2'b11;
  localparam logic [XLEN-1:0] LINK_INC = (IALIGN == 16) ? XLEN'(2) : XLEN'(4);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    if (en && (v != {CNT_W{1'b1}})) return v + CNT_W'(1);
    return v;
  endfunction

  function automatic logic is_misaligned(input logic [XLEN-1:0] t);
    if (IALIGN == 16) return t[0];
    return |t[1:0];
  endfunction

  logic                   w_accept_p0;
  logic                   w_pop_p1;
  logic signed [XLEN-1:0] w_rs1_p0;
  logic signed [XLEN-1:0] w_rs2_p0;
  logic        [XLEN-1:0] w_base_p0;
  logic        [XLEN-1:0] w_sum_p0;
  logic        [XLEN-1:0] w_target_p0;
  logic                   w_taken_p0;
  logic                   w_illegal_p0;

  logic                   r_vld_p1;
  logic [1:0]             r_kind_p1;
  logic                   r_taken_p1;
  logic [XLEN-1:0]        r_target_p1;
  logic [XLEN-1:0]        r_link_p1;
  logic [XLEN-1:0]        r_pc_p1;
  logic                   r_misalign_p1;
  logic                   r_illegal_p1;
  logic [CNT_W-1:0]       r_cnt_res;
  logic [CNT_W-1:0]       r_cnt_tak;

  assign bus.in_ready = !rst && (!r_vld_p1 || bus.out_ready);
  assign w_accept_p0  = bus.in_valid && bus.in_ready && !bus.flush;
  assign w_pop_p1     = r_vld_p1 && bus.out_ready;

  assign w_rs1_p0 = bus.in_rs1;
  assign w_rs2_p0 = bus.in_rs2;

  // Stage p0: resolve target and condition from the incoming request
  always_comb begin
    w_base_p0    = (bus.in_kind == K_JALR) ? bus.in_rs1 : bus.in_pc;
    w_sum_p0     = w_base_p0 + bus.in_imm;
    w_target_p0  = w_sum_p0;
    w_taken_p0   = 1'b0;
    w_illegal_p0 = 1'b0;
    case (bus.in_kind)
      K_JAL:  w_taken_p0 = 1'b1;
      K_JALR: begin
        w_taken_p0     = 1'b1;
        w_target_p0[0] = 1'b0;
      end
      K_BR: begin
        case (bus.in_funct3)
          3'b000:  w_taken_p0 = (w_rs1_p0 == w_rs2_p0);
          3'b001:  w_taken_p0 = (w_rs1_p0 != w_rs2_p0);
          3'b100:  w_taken_p0 = (w_rs1_p0 <  w_rs2_p0);
          3'b101:  w_taken_p0 = (w_rs1_p0 >= w_rs2_p0);
          3'b110:  w_taken_p0 = ($unsigned(w_rs1_p0) <  $unsigned(w_rs2_p0));
          3'b111:  w_taken_p0 = ($unsigned(w_rs1_p0) >= $unsigned(w_rs2_p0));
          default: w_illegal_p0 = 1'b1;
        endcase
      end
      default: w_taken_p0 = 1'b0;
    endcase
  end

  // Stage p1: result buffer; flush wins over accept and pop, counters follow pops only
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld_p1      <= 1'b0;
      r_kind_p1     <= K_NONE;
      r_taken_p1    <= 1'b0;
      r_target_p1   <= '0;
      r_link_p1     <= '0;
      r_pc_p1       <= '0;
      r_misalign_p1 <= 1'b0;
      r_illegal_p1  <= 1'b0;
      r_cnt_res     <= '0;
      r_cnt_tak     <= '0;
    end else begin
      if (bus.flush) begin
        r_vld_p1 <= 1'b0;
      end else if (w_accept_p0) begin
        r_vld_p1      <= 1'b1;
        r_kind_p1     <= bus.in_kind;
        r_taken_p1    <= w_taken_p0;
        r_target_p1   <= w_target_p0;
        r_link_p1     <= bus.in_pc + LINK_INC;
        r_pc_p1       <= bus.in_pc;
        r_misalign_p1 <= w_taken_p0 && is_misaligned(w_target_p0);
        r_illegal_p1  <= w_illegal_p0;
      end else if (w_pop_p1) begin
        r_vld_p1 <= 1'b0;
      end
      if (w_pop_p1) begin
        r_cnt_res <= sat_inc(r_cnt_res, r_kind_p1 != K_NONE);
        r_cnt_tak <= sat_inc(r_cnt_tak, r_taken_p1);
      end
    end
  end

  assign bus.out_valid    = r_vld_p1;
  assign bus.out_taken    = r_taken_p1;
  assign bus.out_target   = r_target_p1;
  assign bus.out_link     = r_link_p1;
  assign bus.out_pc       = r_pc_p1;
  assign bus.out_misalign = r_misalign_p1;
  assign bus.out_illegal  = r_illegal_p1;
  assign bus.cnt_resolved = r_cnt_res;
  assign bus.cnt_taken    = r_cnt_tak;
endmodule

// File: tb/tb_branch_target_unit.sv
// Bench for branch_target_unit: vector table through a scoreboard on the IALIGN=32 unit,
// hand sequences for backpressure, flush and reset, and a small IALIGN=16 / CNT_W=2 unit.
module tb_branch_target_unit;
  typedef struct {
    logic [1:0]  kind;
    logic [2:0]  f3;
    logic [31:0] pc, rs1, rs2, imm;
    logic        taken;
    logic [31:0] target, link;
    logic        mis, ill;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  vec_t sb[$];
  vec_t tbl[14];
  vec_t m_e;

  always #5 clk = ~clk;

  branch_target_if #(.XLEN(32), .CNT_W(32)) bus();
  branch_target_if #(.XLEN(32), .CNT_W(2))  bus2();

  branch_target_unit #(.XLEN(32), .IALIGN(32), .CNT_W(32)) u_dut (.clk(clk), .rst(rst), .bus(bus));
  branch_target_unit #(.XLEN(32), .IALIGN(16), .CNT_W(2))  u_dut16 (.clk(clk), .rst(rst), .bus(bus2));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] kind, input logic [2:0] f3,
                              input logic [31:0] pc, rs1, rs2, imm,
                              input logic taken, input logic [31:0] target, link,
                              input logic mis, ill);
    vec_t v;
    v.kind = kind; v.f3 = f3; v.pc = pc; v.rs1 = rs1; v.rs2 = rs2; v.imm = imm;
    v.taken = taken; v.target = target; v.link = link; v.mis = mis; v.ill = ill;
    return v;
  endfunction

  // Result monitor: every consumed result must match the oldest expected entry
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_underflow actual=result pc %0h required=no result", bus.out_pc);
      end else begin
        m_e = sb.pop_front();
        chk("out_pc",       bus.out_pc,       m_e.pc);
        chk("out_taken",    bus.out_taken,    m_e.taken);
        chk("out_target",   bus.out_target,   m_e.target);
        chk("out_link",     bus.out_link,     m_e.link);
        chk("out_misalign", bus.out_misalign, m_e.mis);
        chk("out_illegal",  bus.out_illegal,  m_e.ill);
      end
    end
  end

  task automatic drive(input vec_t v);
    bus.in_kind = v.kind; bus.in_funct3 = v.f3; bus.in_pc = v.pc;
    bus.in_rs1 = v.rs1; bus.in_rs2 = v.rs2; bus.in_imm = v.imm;
  endtask

  task automatic send(input vec_t v);
    int n = 0;
    drive(v);
    bus.in_valid = 1'b1;
    @(negedge clk);
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("send_ready", bus.in_ready, 1'b1);
    if (bus.in_ready) sb.push_back(v);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_empty", sb.size(), 0);
  endtask

  task automatic run2(input logic [1:0] kind, input logic [31:0] pc, rs1, imm,
                      input logic [31:0] target, link, input logic mis);
    bus2.in_kind = kind; bus2.in_funct3 = 3'b000; bus2.in_pc = pc;
    bus2.in_rs1 = rs1; bus2.in_rs2 = 32'h0; bus2.in_imm = imm;
    bus2.in_valid = 1'b1;
    @(posedge clk); #1;
    bus2.in_valid = 1'b0;
    @(negedge clk);
    chk("a16_valid",    bus2.out_valid,    1'b1);
    chk("a16_taken",    bus2.out_taken,    1'b1);
    chk("a16_target",   bus2.out_target,   target);
    chk("a16_link",     bus2.out_link,     link);
    chk("a16_misalign", bus2.out_misalign, mis);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t va, vb;
    tbl[0]  = mk(2'b01, 3'b000, 32'h100,      32'h0,        32'h0, 32'h20,       1'b1, 32'h120,  32'h104, 1'b0, 1'b0);
    tbl[1]  = mk(2'b10, 3'b000, 32'h200,      32'h2001,     32'h0, 32'h4,        1'b1, 32'h2004, 32'h204, 1'b0, 1'b0);
    tbl[2]  = mk(2'b10, 3'b000, 32'h300,      32'h2002,     32'h0, 32'h0,        1'b1, 32'h2002, 32'h304, 1'b1, 1'b0);
    tbl[3]  = mk(2'b11, 3'b100, 32'h400,      32'hFFFFFFFF, 32'h1, 32'h10,       1'b1, 32'h410,  32'h404, 1'b0, 1'b0);
    tbl[4]  = mk(2'b11, 3'b110, 32'h500,      32'hFFFFFFFF, 32'h1, 32'h10,       1'b0, 32'h510,  32'h504, 1'b0, 1'b0);
    tbl[5]  = mk(2'b11, 3'b010, 32'h600,      32'h0,        32'h0, 32'h8,        1'b0, 32'h608,  32'h604, 1'b0, 1'b1);
    tbl[6]  = mk(2'b11, 3'b000, 32'h700,      32'h5,        32'h5, 32'hFFFFFFFC, 1'b1, 32'h6FC,  32'h704, 1'b0, 1'b0);
    tbl[7]  = mk(2'b11, 3'b001, 32'h800,      32'h5,        32'h5, 32'h40,       1'b0, 32'h840,  32'h804, 1'b0, 1'b0);
    tbl[8]  = mk(2'b11, 3'b101, 32'h900,      32'h80000000, 32'h0, 32'h20,       1'b0, 32'h920,  32'h904, 1'b0, 1'b0);
    tbl[9]  = mk(2'b11, 3'b111, 32'hA00,      32'h80000000, 32'h0, 32'h20,       1'b1, 32'hA20,  32'hA04, 1'b0, 1'b0);
    tbl[10] = mk(2'b01, 3'b000, 32'hFFFFFFFC, 32'h0,        32'h0, 32'h8,        1'b1, 32'h4,    32'h0,   1'b0, 1'b0);
    tbl[11] = mk(2'b00, 3'b000, 32'hB00,      32'h0,        32'h0, 32'h6,        1'b0, 32'hB06,  32'hB04, 1'b0, 1'b0);
    tbl[12] = mk(2'b11, 3'b000, 32'hC00,      32'h0,        32'h0, 32'h2,        1'b1, 32'hC02,  32'hC04, 1'b1, 1'b0);
    tbl[13] = mk(2'b11, 3'b011, 32'hD00,      32'h0,        32'h0, 32'h0,        1'b0, 32'hD00,  32'hD04, 1'b0, 1'b1);

    bus.in_valid = 1'b0; bus.flush = 1'b0; bus.out_ready = 1'b0;
    drive(tbl[0]);
    bus2.in_valid = 1'b0; bus2.flush = 1'b0; bus2.out_ready = 1'b1;
    bus2.in_kind = 2'b00; bus2.in_funct3 = 3'b000; bus2.in_pc = 32'h0;
    bus2.in_rs1 = 32'h0; bus2.in_rs2 = 32'h0; bus2.in_imm = 32'h0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_in_ready",  bus.in_ready,  1'b0);
    chk("rst_target",    bus.out_target, 32'h0);
    chk("rst_link",      bus.out_link,   32'h0);
    chk("rst_cnt_res",   bus.cnt_resolved, 32'h0);
    chk("rst_cnt_tak",   bus.cnt_taken,    32'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", bus.in_ready, 1'b1);
    @(posedge clk); #1;

    // Table, back-to-back with the consumer always ready
    bus.out_ready = 1'b1;
    for (int i = 0; i < 14; i++) send(tbl[i]);
    drain();
    chk("tbl_cnt_res", bus.cnt_resolved, 32'd13);
    chk("tbl_cnt_tak", bus.cnt_taken,    32'd8);

    // Backpressure: A held three cycles while B waits, then both delivered in order
    bus.out_ready = 1'b0;
    va = mk(2'b01, 3'b000, 32'h1000, 32'h0, 32'h0, 32'h10, 1'b1, 32'h1010, 32'h1004, 1'b0, 1'b0);
    vb = mk(2'b01, 3'b000, 32'h2000, 32'h0, 32'h0, 32'h20, 1'b1, 32'h2020, 32'h2004, 1'b0, 1'b0);
    send(va);
    drive(vb);
    bus.in_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("bp_in_ready",  bus.in_ready,   1'b0);
      chk("bp_valid",     bus.out_valid,  1'b1);
      chk("bp_target",    bus.out_target, 32'h1010);
      chk("bp_pc",        bus.out_pc,     32'h1000);
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", bus.in_ready, 1'b1);
    if (bus.in_ready) sb.push_back(vb);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("bp_b_valid", bus.out_valid, 1'b1);
    drain();
    chk("bp_cnt_res", bus.cnt_resolved, 32'd15);
    chk("bp_cnt_tak", bus.cnt_taken,    32'd10);

    // Flush while holding: held result and same-cycle request both discarded
    bus.out_ready = 1'b0;
    send(mk(2'b11, 3'b000, 32'h3000, 32'h1, 32'h1, 32'h8, 1'b1, 32'h3008, 32'h3004, 1'b0, 1'b0));
    drive(mk(2'b01, 3'b000, 32'h3100, 32'h0, 32'h0, 32'h4, 1'b1, 32'h3104, 32'h3104, 1'b0, 1'b0));
    bus.in_valid = 1'b1;
    bus.flush    = 1'b1;
    @(posedge clk); #1;
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    void'(sb.pop_front());
    chk("fl_hold_valid", bus.out_valid,    1'b0);
    chk("fl_hold_res",   bus.cnt_resolved, 32'd15);
    chk("fl_hold_tak",   bus.cnt_taken,    32'd10);

    // Flush with an empty buffer and a ready consumer still drops the request
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.flush     = 1'b1;
    @(posedge clk); #1;
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    chk("fl_empty_valid", bus.out_valid, 1'b0);

    // Flush coinciding with a pop: the popped result still counts
    send(mk(2'b01, 3'b000, 32'h4000, 32'h0, 32'h0, 32'h40, 1'b1, 32'h4040, 32'h4004, 1'b0, 1'b0));
    drive(mk(2'b01, 3'b000, 32'h4100, 32'h0, 32'h0, 32'h4, 1'b1, 32'h4104, 32'h4104, 1'b0, 1'b0));
    bus.in_valid = 1'b1;
    bus.flush    = 1'b1;
    @(posedge clk); #1;
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    chk("fl_pop_valid", bus.out_valid,    1'b0);
    chk("fl_pop_res",   bus.cnt_resolved, 32'd16);
    chk("fl_pop_tak",   bus.cnt_taken,    32'd11);
    chk("fl_pop_sb",    sb.size(),        0);

    // Asynchronous reset while a result is held
    bus.out_ready = 1'b0;
    send(mk(2'b01, 3'b000, 32'h5000, 32'h0, 32'h0, 32'h4, 1'b1, 32'h5004, 32'h5004, 1'b0, 1'b0));
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid",    bus.out_valid,    1'b0);
    chk("arst_cnt_res",  bus.cnt_resolved, 32'd0);
    chk("arst_cnt_tak",  bus.cnt_taken,    32'd0);
    chk("arst_in_ready", bus.in_ready,     1'b0);
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    bus.out_ready = 1'b1;
    send(mk(2'b11, 3'b110, 32'h6000, 32'h1, 32'h2, 32'h100, 1'b1, 32'h6100, 32'h6004, 1'b0, 1'b0));
    drain();
    chk("arst_after_res", bus.cnt_resolved, 32'd1);
    chk("arst_after_tak", bus.cnt_taken,    32'd1);

    // IALIGN=16, CNT_W=2 unit: short link, halfword alignment, counter saturation
    run2(2'b01, 32'h100, 32'h0,    32'h20, 32'h120,  32'h102, 1'b0);
    run2(2'b10, 32'h200, 32'h2002, 32'h0,  32'h2002, 32'h202, 1'b0);
    chk("a16_cnt_tak_2", bus2.cnt_taken, 2'd2);
    run2(2'b01, 32'h300, 32'h0,    32'h1,  32'h301,  32'h302, 1'b1);
    chk("a16_cnt_tak_3", bus2.cnt_taken, 2'd3);
    run2(2'b01, 32'h400, 32'h0,    32'h4,  32'h404,  32'h402, 1'b0);
    run2(2'b01, 32'h500, 32'h0,    32'h8,  32'h508,  32'h502, 1'b0);
    chk("a16_sat_tak", bus2.cnt_taken,    2'd3);
    chk("a16_sat_res", bus2.cnt_resolved, 2'd3);

    chk("final_sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
